// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst/lock ownership hold and default-master parking
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 16,
  parameter int MASTER_W       = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK
);
  typedef enum logic [1:0] {ARB, BURST, LOCKED, LOCK_TAIL} state_t;
  localparam logic [MASTER_W-1:0] DEF = MASTER_W'(DEFAULT_MASTER);
  state_t state_q, state_d;
  logic [MASTER_W-1:0] own_q, own_d, ptr_q, ptr_d, mst_q, mst_d, win;
  logic [3:0] cnt_q, cnt_d, load;
  logic mlock_q, mlock_d, permit, own_lock, win_lock, nonseq_fixed, seq, idle;
  int sum;
  assign HGRANT       = NUM_MASTERS'(1) << own_q;
  assign HMASTER      = mst_q;
  assign HMASTLOCK    = mlock_q;
  assign own_lock     = |(HLOCK & (NUM_MASTERS'(1) << own_q));
  assign win_lock     = |(HLOCK & (NUM_MASTERS'(1) << win));
  assign seq          = HTRANS == 2'b11;
  assign idle         = HTRANS == 2'b00;
  assign nonseq_fixed = HTRANS == 2'b10 && HBURST[2:1] != 2'b00;
  assign load         = HBURST[2] ? (HBURST[1] ? 4'd14 : 4'd6) : 4'd2;
  // round-robin search starting just after the pointer; the pointer itself is tried last
  always_comb begin
    win = ptr_q;
    sum = 0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      sum = int'(ptr_q) + i;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      if (|(HBUSREQ & (NUM_MASTERS'(1) << sum))) win = MASTER_W'(sum);
    end
  end
  // per-accepted-transfer bookkeeping; every register holds while HREADY is low
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    mst_d   = mst_q;
    mlock_d = mlock_q;
    cnt_d   = cnt_q;
    permit  = 1'b0;
    if (HREADY) begin
      mst_d   = own_q;
      mlock_d = own_lock;
      case (state_q)
        ARB: begin
          cnt_d   = nonseq_fixed ? load : cnt_q;
          state_d = nonseq_fixed ? BURST : ARB;
          permit  = !nonseq_fixed;
        end
        BURST: begin
          permit  = idle || (seq && cnt_q == 4'd0);
          state_d = permit ? ARB : BURST;
          cnt_d   = (seq && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        end
        LOCKED: begin
          cnt_d   = nonseq_fixed ? load : (seq && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
          state_d = own_lock ? LOCKED : LOCK_TAIL;
        end
        default: begin
          state_d = ARB;
          permit  = 1'b1;
        end
      endcase
      if (permit) begin
        own_d = |HBUSREQ ? win : DEF;
        ptr_d = |HBUSREQ ? win : ptr_q;
        if (|HBUSREQ && win_lock) state_d = LOCKED;
      end
    end
  end
  // state registers, asynchronously parked on the default master
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB;
      own_q   <= DEF;
      ptr_q   <= DEF;
      mst_q   <= DEF;
      mlock_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      mst_q   <= mst_d;
      mlock_q <= mlock_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
